// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle MIPS sequencer and the datapath mux decoders.
package multicycle_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11
  } state_t;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0011;
  localparam logic [3:0] ALU_SUB   = 4'b0100;
  localparam logic [3:0] ALU_LUI   = 4'b0101;
  localparam logic [3:0] ALU_FUNCT = 4'b0111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;
  localparam logic [1:0] M2R_LUI    = 2'b11;

  localparam logic       SRCA_PC = 1'b0;
  localparam logic       SRCA_RS = 1'b1;

  localparam logic [2:0] SRCB_RT      = 3'b000;
  localparam logic [2:0] SRCB_FOUR    = 3'b001;
  localparam logic [2:0] SRCB_SEXT    = 3'b010;
  localparam logic [2:0] SRCB_SEXT_SH = 3'b011;
  localparam logic [2:0] SRCB_ZEXT    = 3'b100;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that talk to the unified memory and therefore wait on mem_ready.
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Counts consecutive not-ready memory cycles and flags the cycle that hits the limit.
module multicycle_control_fsm_mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_timeout
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] r_count;

  // The limit is reached when the count already holds TIMEOUT_CYCLES-1 waits
  // and this cycle is yet another wait.
  always_comb begin
    o_timeout = (TIMEOUT_CYCLES != 0) && i_enable && (r_count == LAST);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear || o_timeout) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + W'(1);
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore sequencer stepping the shared multicycle datapath, with memory wait timeout.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCondEQ,
  output logic       PCWriteCondNE,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [2:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       bus_error,
  output logic [3:0] state
);

  state_t r_state;
  state_t w_next;
  logic   w_mem_state;
  logic   w_timeout;

  assign state       = r_state;
  assign w_mem_state = is_mem_state(r_state);

  multicycle_control_fsm_mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk    (clk),
    .i_rst    (reset),
    .i_clear  (!w_mem_state || mem_ready),
    .i_enable (w_mem_state && !mem_ready),
    .o_timeout(w_timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    PCWrite       = 1'b0;
    PCWriteCondEQ = 1'b0;
    PCWriteCondNE = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    RegDst        = REGDST_RT;
    MemtoReg      = M2R_ALUOUT;
    RegWrite      = 1'b0;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RT;
    ALUOp         = ALU_AND;
    PCSource      = PCSRC_ALU;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    bus_error     = 1'b0;

    case (r_state)
      S_FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        ALUOp    = ALU_ADD;
        IRWrite  = mem_ready;
        PCWrite  = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_SEXT_SH;
        ALUOp   = ALU_ADD;
        case (OP)
          OP_RTYPE:                      w_next = S_R_EXEC;
          OP_ADDI, OP_ANDI, OP_ORI,
          OP_LUI:                        w_next = S_I_EXEC;
          OP_LW, OP_SW:                  w_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                w_next = S_BRANCH;
          OP_J, OP_JAL:                  w_next = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            w_next     = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = SRCA_RS;
        ALUSrcB = SRCB_SEXT;
        ALUOp   = ALU_ADD;
        w_next  = (OP == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        RegWrite   = 1'b1;
        RegDst     = REGDST_RT;
        MemtoReg   = M2R_MDR;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
      end
      S_R_EXEC: begin
        ALUSrcA = SRCA_RS;
        ALUSrcB = SRCB_RT;
        ALUOp   = ALU_FUNCT;
        w_next  = S_R_WB;
      end
      S_R_WB: begin
        RegWrite   = 1'b1;
        RegDst     = REGDST_RD;
        MemtoReg   = M2R_ALUOUT;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_I_EXEC: begin
        ALUSrcA = SRCA_RS;
        w_next  = S_I_WB;
        case (OP)
          OP_ANDI: begin ALUSrcB = SRCB_ZEXT; ALUOp = ALU_AND; end
          OP_ORI:  begin ALUSrcB = SRCB_ZEXT; ALUOp = ALU_OR;  end
          OP_LUI:  begin ALUSrcB = SRCB_SEXT; ALUOp = ALU_LUI; end
          default: begin ALUSrcB = SRCB_SEXT; ALUOp = ALU_ADD; end
        endcase
      end
      S_I_WB: begin
        RegWrite   = 1'b1;
        RegDst     = REGDST_RT;
        MemtoReg   = (OP == OP_LUI) ? M2R_LUI : M2R_ALUOUT;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA       = SRCA_RS;
        ALUSrcB       = SRCB_RT;
        ALUOp         = ALU_SUB;
        PCSource      = PCSRC_ALUOUT;
        PCWriteCondEQ = (OP == OP_BEQ);
        PCWriteCondNE = (OP == OP_BNE);
        instr_done    = 1'b1;
        w_next        = S_FETCH;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = PCSRC_JUMP;
        instr_done = 1'b1;
        if (OP == OP_JAL) begin
          RegWrite = 1'b1;
          RegDst   = REGDST_RA;
          MemtoReg = M2R_PC;
        end
        w_next = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase

    // A timeout only fires while mem_ready is low, so the completion-gated
    // strobes are already 0 here; just abort to a refetch.
    if (w_timeout) begin
      bus_error = 1'b1;
      w_next    = S_FETCH;
    end

    if (reset) begin
      PCWrite       = 1'b0;
      PCWriteCondEQ = 1'b0;
      PCWriteCondNE = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      RegWrite      = 1'b0;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
      bus_error     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed and random instruction streams checked cycle by cycle against a phase-level model.
module tb_multicycle_control_fsm;

  localparam int unsigned TMO = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] OP = 6'h00;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite;
  logic [1:0] RegDst, MemtoReg, PCSource;
  logic       RegWrite, ALUSrcA;
  logic [2:0] ALUSrcB;
  logic [3:0] ALUOp, state;
  logic       instr_done, illegal_op, bus_error;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .OP(OP), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCondEQ(PCWriteCondEQ), .PCWriteCondNE(PCWriteCondNE),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .instr_done(instr_done),
    .illegal_op(illegal_op), .bus_error(bus_error), .state(state)
  );

  typedef struct packed {
    logic       pcw, pceq, pcne, iord, mrd, mwr, irw;
    logic [1:0] regdst, m2r;
    logic       rw, srca;
    logic [2:0] srcb;
    logic [3:0] aluop;
    logic [1:0] pcsrc;
    logic       done, ill, berr;
    logic [3:0] st;
  } ctl_t;

  typedef struct {
    logic [3:0] st;
    logic       rdy;
    logic       tmo;
    logic [5:0] op;
  } cyc_t;

  cyc_t q[$];
  int   total = 0;
  int   bad = 0;
  bit   rand_ready = 1'b0;

  function automatic bit is_legal(logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b};
  endfunction

  function automatic ctl_t observed();
    ctl_t o;
    o.pcw = PCWrite;  o.pceq = PCWriteCondEQ; o.pcne = PCWriteCondNE; o.iord = IorD;
    o.mrd = MemRead;  o.mwr = MemWrite; o.irw = IRWrite; o.regdst = RegDst; o.m2r = MemtoReg;
    o.rw = RegWrite;  o.srca = ALUSrcA; o.srcb = ALUSrcB; o.aluop = ALUOp; o.pcsrc = PCSource;
    o.done = instr_done; o.ill = illegal_op; o.berr = bus_error; o.st = state;
    return o;
  endfunction

  // Control word each phase must present, written straight from the instruction-phase table.
  function automatic ctl_t expect_ctl(cyc_t c);
    ctl_t e = '0;
    e.st = c.st;
    case (c.st)
      0:  begin e.mrd = 1; e.srcb = 3'd1; e.aluop = 4'd3; e.irw = c.rdy; e.pcw = c.rdy; e.berr = c.tmo; end
      1:  begin e.srcb = 3'd3; e.aluop = 4'd3; e.ill = !is_legal(c.op); end
      2:  begin e.srca = 1; e.srcb = 3'd2; e.aluop = 4'd3; end
      3:  begin e.mrd = 1; e.iord = 1; e.berr = c.tmo; end
      4:  begin e.rw = 1; e.m2r = 2'd1; e.done = 1; end
      5:  begin e.mwr = 1; e.iord = 1; e.done = c.rdy; e.berr = c.tmo; end
      6:  begin e.srca = 1; e.aluop = 4'd7; end
      7:  begin e.rw = 1; e.regdst = 2'd1; e.done = 1; end
      8:  begin
            e.srca = 1;
            case (c.op)
              6'h0c:   begin e.srcb = 3'd4; e.aluop = 4'd0; end
              6'h0d:   begin e.srcb = 3'd4; e.aluop = 4'd1; end
              6'h0f:   begin e.srcb = 3'd2; e.aluop = 4'd5; end
              default: begin e.srcb = 3'd2; e.aluop = 4'd3; end
            endcase
          end
      9:  begin e.rw = 1; e.m2r = (c.op == 6'h0f) ? 2'd3 : 2'd0; e.done = 1; end
      10: begin e.srca = 1; e.aluop = 4'd4; e.pcsrc = 2'd1; e.pceq = (c.op == 6'h04);
                e.pcne = (c.op == 6'h05); e.done = 1; end
      11: begin e.pcw = 1; e.pcsrc = 2'd2; e.done = 1;
                if (c.op == 6'h03) begin e.rw = 1; e.regdst = 2'd2; e.m2r = 2'd2; end end
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic push(input logic [3:0] st, input logic rdy, input logic tmo, input logic [5:0] op);
    cyc_t c;
    c.st = st; c.rdy = rdy; c.tmo = tmo; c.op = op;
    q.push_back(c);
  endtask

  task automatic push_plain(input logic [3:0] st, input logic [5:0] op);
    push(st, rand_ready ? 1'($urandom % 2) : 1'b1, 1'b0, op);
  endtask

  // A memory phase lasts waits+1 cycles, or is cut to TMO cycles with a bus error.
  task automatic mem_phase(input logic [3:0] st, input int unsigned waits, input logic [5:0] op,
                           output bit ok);
    if (waits >= TMO) begin
      for (int unsigned i = 0; i < TMO; i++) push(st, 1'b0, (i == TMO - 1), op);
      ok = 1'b0;
    end else begin
      for (int unsigned i = 0; i < waits; i++) push(st, 1'b0, 1'b0, op);
      push(st, 1'b1, 1'b0, op);
      ok = 1'b1;
    end
  endtask

  task automatic build(input logic [5:0] op, input int unsigned wf, input int unsigned wm,
                       output int retire);
    bit ok;
    retire = 0;
    mem_phase(4'd0, wf, op, ok);
    if (!ok) return;
    push_plain(4'd1, op);
    if (!is_legal(op)) return;
    retire = 1;
    case (op)
      6'h00: begin push_plain(4'd6, op); push_plain(4'd7, op); end
      6'h08, 6'h0c, 6'h0d, 6'h0f: begin push_plain(4'd8, op); push_plain(4'd9, op); end
      6'h23: begin
        push_plain(4'd2, op);
        mem_phase(4'd3, wm, op, ok);
        if (ok) push_plain(4'd4, op); else retire = 0;
      end
      6'h2b: begin
        push_plain(4'd2, op);
        mem_phase(4'd5, wm, op, ok);
        if (!ok) retire = 0;
      end
      6'h04, 6'h05: push_plain(4'd10, op);
      default: push_plain(4'd11, op);
    endcase
  endtask

  task automatic play(input string name, output int ndone);
    cyc_t c;
    int   n = 0;
    ndone = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      OP = c.op;
      mem_ready = c.rdy;
      #1;
      chk($sformatf("%s_c%0d_st%0d", name, n, c.st), 32'(observed()), 32'(expect_ctl(c)));
      if (instr_done) ndone++;
      n++;
    end
  endtask

  task automatic reset_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1;
      mem_ready = 1'b1;
      #1;
      chk($sformatf("reset_strobes%0d", i),
          {22'b0, PCWrite, PCWriteCondEQ, PCWriteCondNE, MemRead, MemWrite, IRWrite,
           RegWrite, instr_done, illegal_op, bus_error}, 32'd0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run(input string name, input logic [5:0] op, input int unsigned wf,
                     input int unsigned wm);
    int ret, nd;
    build(op, wf, wm, ret);
    play(name, nd);
    chk({name, "_done"}, nd, ret);
  endtask

  initial begin
    int ret, nd;
    logic [5:0] legal [11];
    legal = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b};

    reset_cycles(2);

    // LW interrupted while waiting in MEM_READ, then reset held 3 cycles.
    build(6'h23, 0, 2, ret);
    void'(q.pop_back());
    void'(q.pop_back());
    play("lw_cut", nd);
    reset_cycles(3);

    run("rtype", 6'h00, 0, 0);
    run("lw_wait2", 6'h23, 0, 2);
    run("bne", 6'h05, 0, 0);
    run("jal", 6'h03, 0, 0);
    run("beq", 6'h04, 0, 0);
    run("illegal3f", 6'h3f, 0, 0);
    run("sw_stuck", 6'h2b, 0, TMO + 2);
    run("sw_rdy_last", 6'h2b, 0, TMO - 1);
    run("fetch_tmo", 6'h00, TMO + 1, 0);
    run("lw_tmo", 6'h23, 1, TMO);
    run("lui", 6'h0f, TMO - 1, 0);

    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [5:0] op;
      int unsigned wf, wm;
      op = ($urandom % 8 == 0) ? 6'($urandom) : legal[$urandom % 11];
      wf = ($urandom % 12 == 0) ? TMO + ($urandom % 2) : $urandom % TMO;
      wm = ($urandom % 10 == 0) ? TMO + ($urandom % 2) : $urandom % TMO;
      run($sformatf("rnd%0d", i), op, wf, wm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Sequencing controller for the multicycle variant of the MIPS core; replaces the single-cycle opcode decoder with a Moore FSM that steps the shared datapath (one ALU, one unified memory, IR, ALUOut) through fetch/decode/execute/memory/writeback.
- Handles memory wait states through a ready handshake with a timeout, and flags illegal opcodes.
- ALUOp encodings match the ALU control unit: AND 0000, OR 0001, ADD 0011, SUB 0100, LUI 0101, R-type/funct 0111.

Parameters:
TIMEOUT_CYCLES, 16, consecutive not-ready cycles in a memory state before bus_error; 0 disables the timeout.

Ports:
clk  in  1  system clock; all state changes on its rising edge.
reset  in  1  synchronous, active-high reset.
OP  in  6  opcode IR[31:26]; IR is stable from DECODE until the next fetch.
mem_ready  in  1  memory access completes in the cycle it is high.
PCWrite  out  1  unconditional PC load.
PCWriteCondEQ  out  1  PC load if ALU zero.
PCWriteCondNE  out  1  PC load if not zero.
IorD  out  1  memory address source: 0 PC, 1 ALUOut.
MemRead  out  1  memory read strobe.
MemWrite  out  1  memory write strobe.
IRWrite  out  1  IR load.
RegDst  out  2  00 rt, 01 rd, 10 ra.
MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC (already PC+4), 11 LUI immediate.
RegWrite  out  1  register file write.
ALUSrcA  out  1  0 PC, 1 rs.
ALUSrcB  out  3  000 rt, 001 const 4, 010 sign-ext, 011 sign-ext<<2, 100 zero-ext.
ALUOp  out  4  see Overview.
PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump address.
instr_done  out  1  1-cycle pulse on the last cycle of a retired instruction.
illegal_op  out  1  1-cycle pulse, unknown opcode in DECODE.
bus_error  out  1  1-cycle pulse, memory timeout.
state  out  4  current state (debug).

Behaviour:
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, I_EXEC 8, I_WB 9, BRANCH 10, JUMP 11.
- Reset: state <= FETCH and wait counter <= 0 on the clock edge.
  - While reset is high, every strobe (PCWrite, PCWriteCond*, MemRead, MemWrite, IRWrite, RegWrite) and every pulse output is forced to 0.
  - Reset asserted mid-instruction aborts it with no writes.
- Unlisted outputs are 0 in a state. Outputs are decoded from state, plus OP where noted, plus mem_ready where noted.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=001, ALUOp=ADD, PCSource=00. IRWrite and PCWrite equal mem_ready. On mem_ready go to DECODE, else stay.
- DECODE: ALUSrcA=0, ALUSrcB=011, ADD (branch target into ALUOut). Next state by OP:
  - 00 -> R_EXEC
  - 08/0c/0d/0f -> I_EXEC
  - 23/2b -> MEM_ADDR
  - 04/05 -> BRANCH
  - 02/03 -> JUMP
  - any other OP: illegal_op=1 for this cycle, go to FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=010, ADD. Next is MEM_READ for 23, MEM_WRITE for 2b.
- MEM_READ: MemRead=1, IorD=1. On mem_ready go to MEM_WB.
- MEM_WB: RegWrite=1, RegDst=00, MemtoReg=01, instr_done=1, go to FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. On mem_ready: instr_done=1, go to FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=000, ALUOp=0111, go to R_WB.
- R_WB: RegWrite=1, RegDst=01, MemtoReg=00, instr_done=1, go to FETCH.
- I_EXEC: ALUSrcA=1, go to I_WB. Per OP:
  - ADDI: ALUSrcB=010, ADD
  - ANDI: ALUSrcB=100, AND
  - ORI: ALUSrcB=100, OR
  - LUI: ALUSrcB=010, ALUOp=0101
- I_WB: RegWrite=1, RegDst=00, MemtoReg=11 for LUI else 00, instr_done=1, go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=000, SUB, PCSource=01. PCWriteCondEQ=1 for BEQ, PCWriteCondNE=1 for BNE. instr_done=1, go to FETCH.
- JUMP: PCWrite=1, PCSource=10. For JAL also RegWrite=1, RegDst=10, MemtoReg=10. instr_done=1, go to FETCH.
- Base latencies (cycles, excluding waits): LW 5, SW/R/I 4, branch/jump 3. Each not-ready cycle adds one.
- Wait counter:
  - Width $clog2(TIMEOUT_CYCLES+1).
  - Cleared on entry to FETCH, MEM_READ and MEM_WRITE, and whenever mem_ready=1.
  - Increments on each not-ready cycle in those states.
- Timeout: if mem_ready is still 0 in the TIMEOUT_CYCLES-th consecutive wait cycle, bus_error=1 that cycle, the state's write strobes stay 0, and the next state is FETCH (PC unchanged, refetch).
- mem_ready=1 in the timeout cycle wins: normal completion, no bus_error.
- mem_ready is ignored in non-memory states.

Decomposition:
- Shared package: state encoding localparams, ALUOp codes, opcode constants, and the RegDst/MemtoReg/ALUSrcB/PCSource select codes (shared with the datapath mux select decoding).
- One sub-module: mem_wait_timer (counter, clear/enable, timeout flag). The FSM itself stays in a single module.

Test Plan:
- reset held 3 cycles mid-LW -> all strobes 0 during reset; state=0 on the cycle after release; no RegWrite.
- R-type (OP=00), mem_ready=1 constant:
  - states 0,1,6,7
  - IRWrite/PCWrite high in cycle 0; ALUOp=0111 in state 6; RegWrite=1, RegDst=01 in state 7
  - instr_done once.
- LW (OP=23), mem_ready low 2 cycles in MEM_READ -> states 0,1,2,3,3,3,4 (7 cycles); RegWrite=1 and MemtoReg=01 only in state 4.
- BNE (OP=05) -> state 10 has PCWriteCondNE=1, PCWriteCondEQ=0, ALUOp=0100, PCSource=01; JAL (OP=03) -> state 11 has PCWrite=1, RegWrite=1, RegDst=10, MemtoReg=10.
- OP=3f -> illegal_op pulses in DECODE, then FETCH; no RegWrite/MemWrite; instr_done stays 0.
- TIMEOUT_CYCLES=4:
  - SW with mem_ready stuck 0 -> bus_error on the 4th MEM_WRITE cycle, MemWrite is 1 only while in state 5 (never a write strobe outside), next state FETCH.
  - same with mem_ready=1 on the 4th cycle -> no bus_error, instr_done=1.
